// File: rtl/alu_queue_pkg.sv
// Shared types for the ALU operation queue: op codes, queue entry layout, reader FSM states.
// No logic here. Entry field widths set the default DATA_W/CTRL_W of the queue modules.
// Flow control is handled by the users of these types.
package alu_queue_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_CTRL_W = 2;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_MUL = 2;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] ctrl;
        logic [ALU_DATA_W-1:0] x;
        logic [ALU_DATA_W-1:0] z;
    } alu_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_queue_reader_if.sv
// Writer-side push bus, queue status and result valid/ready channel of the ALU queue.
// Wires only; no latency. Pushes are dropped while full; the result channel stalls on y_ready.
// The DUT uses the slave modport; the writer/consumer side uses master.
interface alu_queue_reader_if #(
    parameter int DATA_W      = 8,
    parameter int CTRL_W      = 2,
    parameter int MAX_Q_DEPTH = 8
);
    localparam int CNT_W = $clog2(MAX_Q_DEPTH) + 1;

    logic                push;
    logic [CTRL_W-1:0]   push_ctrl;
    logic [DATA_W-1:0]   push_x;
    logic [DATA_W-1:0]   push_z;
    logic                full;
    logic [CNT_W-1:0]    number_queued;
    logic                overflow;
    logic                y_valid;
    logic                y_ready;
    logic [2*DATA_W-1:0] y;
    logic                y_err;

    modport slave (
        input  push, push_ctrl, push_x, push_z, y_ready,
        output full, number_queued, overflow, y_valid, y, y_err
    );

    modport master (
        output push, push_ctrl, push_x, push_z, y_ready,
        input  full, number_queued, overflow, y_valid, y, y_err
    );
endinterface

// File: rtl/alu_queue_fifo.sv
// Operation queue storage with occupancy, full and overflow status.
// Push visible in number_queued one cycle later; head entry is read combinationally.
// Pushes while full are dropped and flagged by a one-cycle overflow pulse.
module alu_queue_fifo
    import alu_queue_pkg::*;
#(
    parameter int MAX_Q_DEPTH = 8,
    localparam int PTR_W = $clog2(MAX_Q_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  alu_entry_t       push_dat,
    input  logic             pop,
    output alu_entry_t       head_dat,
    output logic             full,
    output logic [CNT_W-1:0] number_queued,
    output logic             overflow
);

    alu_entry_t       mem_q [MAX_Q_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             push_acc;

    // Acceptance uses the registered full, so a same-cycle pop never makes room.
    always_comb begin
        push_acc   = push && !full_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        cnt_d      = cnt_q + CNT_W'(push_acc) - CNT_W'(pop);
        full_d     = (cnt_d == CNT_W'(MAX_Q_DEPTH));
        overflow_d = push && full_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat      = mem_q[rd_ptr_q];
    assign full          = full_q;
    assign number_queued = cnt_q;
    assign overflow      = overflow_q;

endmodule

// File: rtl/alu_queue_reader.sv
// Drains the ALU op queue in order, executes each entry, presents {y, y_err} on valid/ready. Macro ALU_QUEUE_MUL_EN enables ctrl 2 multiply.
// Latency: push edge -> pop 1 cycle -> y_valid 2 cycles; one result per 2 cycles sustained.
// y/y_err/y_valid hold until y_ready; queue fills behind a stalled result and drops extra pushes.
module alu_queue_reader
    import alu_queue_pkg::*;
#(
    parameter int DATA_W      = ALU_DATA_W,
    parameter int CTRL_W      = ALU_CTRL_W,
    parameter int MAX_Q_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_queue_reader_if.slave  bus
);

    alu_entry_t          push_dat;
    alu_entry_t          head_dat;
    logic                pop;

    alu_state_t          state_q, state_d;
    alu_entry_t          opnd_q, opnd_d;
    logic [2*DATA_W-1:0] y_q, y_d;
    logic                y_err_q, y_err_d;
    logic                y_vld_q, y_vld_d;

    logic [2*DATA_W-1:0] x_ext, z_ext;
    logic [2*DATA_W-1:0] alu_y;
    logic                alu_err;
    logic                q_nonempty;

    assign push_dat = '{ctrl: bus.push_ctrl, x: bus.push_x, z: bus.push_z};

    alu_queue_fifo #(
        .MAX_Q_DEPTH (MAX_Q_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (bus.push),
        .push_dat      (push_dat),
        .pop           (pop),
        .head_dat      (head_dat),
        .full          (bus.full),
        .number_queued (bus.number_queued),
        .overflow      (bus.overflow)
    );

    assign q_nonempty = (bus.number_queued != '0);
    assign x_ext      = {{DATA_W{1'b0}}, opnd_q.x};
    assign z_ext      = {{DATA_W{1'b0}}, opnd_q.z};

    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (opnd_q.ctrl)
            CTRL_W'(ALU_ADD): alu_y = x_ext + z_ext;
            CTRL_W'(ALU_SUB): alu_y = x_ext - z_ext;
`ifdef ALU_QUEUE_MUL_EN
            CTRL_W'(ALU_MUL): alu_y = x_ext * z_ext;
`endif
            default:          alu_err = 1'b1;
        endcase
    end

    // The handshake edge both retires the held result and pops the next entry.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        y_d     = y_q;
        y_err_d = y_err_q;
        y_vld_d = y_vld_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (q_nonempty) begin
                    pop     = 1'b1;
                    opnd_d  = head_dat;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d     = alu_y;
                y_err_d = alu_err;
                y_vld_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.y_ready) begin
                    y_vld_d = 1'b0;
                    if (q_nonempty) begin
                        pop     = 1'b1;
                        opnd_d  = head_dat;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            y_q     <= '0;
            y_err_q <= 1'b0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            y_q     <= y_d;
            y_err_q <= y_err_d;
            y_vld_q <= y_vld_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_err   = y_err_q;
    assign bus.y_valid = y_vld_q;

endmodule

// File: tb/tb_alu_queue_reader.sv
// Self-checking bench for alu_queue_reader: directed vector table, overflow/stall/reset sequences,
// then randomized traffic against an in-order scoreboard of expected ALU results.
module tb_alu_queue_reader;

    localparam int DATA_W = 8;
    localparam int CTRL_W = 2;
    localparam int DEPTH  = 8;
`ifdef ALU_QUEUE_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_queue_reader_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .MAX_Q_DEPTH(DEPTH)) bus ();

    alu_queue_reader #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .MAX_Q_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  ctrl;
        logic [7:0]  x;
        logic [7:0]  z;
        logic [15:0] exp_y;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result {err, y} from the operation rules, using plain integer arithmetic.
    function automatic logic [16:0] ref_op(input int ctrl, input int x, input int z);
        int r;
        if (ctrl == 0) begin
            r = (x + z) % 65536;
            return {1'b0, 16'(r)};
        end else if (ctrl == 1) begin
            r = (x - z + 65536) % 65536;
            return {1'b0, 16'(r)};
        end else if (ctrl == 2 && MUL_ON) begin
            r = x * z;
            return {1'b0, 16'(r)};
        end
        return {1'b1, 16'd0};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_y_valid"}, 32'(bus.y_valid), 0);
        check({tag, "_y"}, 32'(bus.y), 0);
        check({tag, "_y_err"}, 32'(bus.y_err), 0);
        check({tag, "_overflow"}, 32'(bus.overflow), 0);
        check({tag, "_full"}, 32'(bus.full), 0);
        check({tag, "_number_queued"}, 32'(bus.number_queued), 0);
    endtask

    // One isolated push with y_ready high: latency, result and drain back to empty.
    task automatic run_single(input vec_t v, input string tag);
        int lat;
        bus.y_ready   = 1'b1;
        bus.push      = 1'b1;
        bus.push_ctrl = v.ctrl;
        bus.push_x    = v.x;
        bus.push_z    = v.z;
        step();
        bus.push = 1'b0;
        check({tag, "_nq_after_push"}, 32'(bus.number_queued), 1);
        lat = 0;
        while (!bus.y_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 2);
        check({tag, "_y"}, 32'(bus.y), 32'(v.exp_y));
        check({tag, "_y_err"}, 32'(bus.y_err), 32'(v.exp_err));
        step();
        check({tag, "_valid_cleared"}, 32'(bus.y_valid), 0);
        check({tag, "_nq_empty"}, 32'(bus.number_queued), 0);
    endtask

    initial begin
        logic [15:0] cap_y;
        logic        cap_err;
        logic        ok;
        int          got;
        logic        prev_push, prev_full, prev_vld, prev_rdy, prev_err;
        logic [15:0] prev_y;
        logic [16:0] exp_r;
        int          nq, inflight;

        vecs[0] = '{2'd0, 8'd5,   8'd3,   16'd8,    1'b0};
        vecs[1] = '{2'd1, 8'd3,   8'd5,   16'hFFFE, 1'b0};
        vecs[2] = '{2'd3, 8'd1,   8'd1,   16'h0000, 1'b1};
        vecs[3] = '{2'd2, 8'd255, 8'd255, MUL_ON ? 16'hFE01 : 16'h0000, !MUL_ON};
        vecs[4] = '{2'd0, 8'd255, 8'd255, 16'h01FE, 1'b0};
        vecs[5] = '{2'd1, 8'd0,   8'd255, 16'hFF01, 1'b0};
        vecs[6] = '{2'd1, 8'd200, 8'd100, 16'h0064, 1'b0};
        vecs[7] = '{2'd2, 8'd12,  8'd10,  MUL_ON ? 16'd120 : 16'd0, !MUL_ON};

        bus.push      = 1'b0;
        bus.push_ctrl = '0;
        bus.push_x    = '0;
        bus.push_z    = '0;
        bus.y_ready   = 1'b0;

        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // Fill behind a stalled result: entry 0 sits in the FSM, 8 in the queue, 1 dropped.
        bus.y_ready = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.push      = 1'b1;
            bus.push_ctrl = 2'd0;
            bus.push_x    = 8'(i);
            bus.push_z    = 8'd1;
            step();
            if (i <= 8 && bus.overflow) ok = 1'b0;
            if (i == 7) check("fill_not_full_yet", 32'(bus.full), 0);
            if (i == 8) begin
                check("fill_full", 32'(bus.full), 1);
                check("fill_nq", 32'(bus.number_queued), 8);
            end
        end
        check("fill_no_early_overflow", 32'(ok), 1);
        check("fill_overflow_pulse", 32'(bus.overflow), 1);
        check("fill_nq_after_drop", 32'(bus.number_queued), 8);
        bus.push = 1'b0;
        step();
        check("fill_overflow_one_cycle", 32'(bus.overflow), 0);

        cap_y   = bus.y;
        cap_err = bus.y_err;
        check("stall_first_y", 32'(cap_y), 1);
        ok = bus.y_valid;
        for (int c = 0; c < 5; c++) begin
            step();
            if (!bus.y_valid || bus.y !== cap_y || bus.y_err !== cap_err) ok = 1'b0;
        end
        check("stall_stable", 32'(ok), 1);

        bus.y_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.y_valid) begin
                check($sformatf("drain_order%0d", got), 32'(bus.y), 32'(got + 1));
                got++;
            end
            step();
        end
        check("drain_count", 32'(got), 9);
        check("drain_nq", 32'(bus.number_queued), 0);

        // Reset while a result is held and entries are queued.
        bus.y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.push      = 1'b1;
            bus.push_ctrl = 2'd0;
            bus.push_x    = 8'(16 + i);
            bus.push_z    = 8'd0;
            step();
        end
        bus.push = 1'b0;
        step();
        step();
        check("pre_reset_holding", 32'(bus.y_valid), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step();
        rst_n = 1'b1;
        bus.y_ready = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.y_valid || bus.number_queued != 0) ok = 1'b0;
        end
        check("post_reset_no_stale", 32'(ok), 1);
        run_single(vecs[0], "post_reset");

        // Randomized traffic against an in-order scoreboard.
        prev_push = 1'b0;
        prev_full = 1'b0;
        prev_vld  = 1'b0;
        prev_rdy  = 1'b0;
        prev_y    = '0;
        prev_err  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            check("rnd_overflow", 32'(bus.overflow), 32'(prev_push && prev_full));
            if (prev_vld && !prev_rdy) begin
                check("rnd_hold_stable", {15'd0, bus.y_valid, bus.y_err, bus.y},
                      {15'd0, 1'b1, prev_err, prev_y});
            end
            nq       = int'(bus.number_queued);
            inflight = exp_q.size();
            check("rnd_occupancy", 32'(nq == inflight || nq == inflight - 1), 1);
            check("rnd_full_flag", 32'(bus.full), 32'(nq == DEPTH));

            bus.y_ready = (c >= 1400) ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (bus.y_valid && bus.y_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_result", 32'(bus.y), 32'hDEAD);
                end else begin
                    exp_r = exp_q.pop_front();
                    check("rnd_result", {15'd0, bus.y_err, bus.y}, {15'd0, exp_r});
                end
            end
            bus.push      = (c < 1400) ? ($urandom_range(0, 1) == 1) : 1'b0;
            bus.push_ctrl = 2'($urandom_range(0, 3));
            bus.push_x    = 8'($urandom);
            bus.push_z    = 8'($urandom);
            if (bus.push && !bus.full) begin
                exp_q.push_back(ref_op(int'(bus.push_ctrl), int'(bus.push_x), int'(bus.push_z)));
            end
            prev_push = bus.push;
            prev_full = bus.full;
            prev_vld  = bus.y_valid;
            prev_rdy  = bus.y_ready;
            prev_y    = bus.y;
            prev_err  = bus.y_err;
            step();
        end
        check("rnd_scoreboard_empty", 32'(exp_q.size()), 0);
        check("rnd_final_valid", 32'(bus.y_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_queue_reader.md
# alu_queue_reader

Consumer end of the ALU operation queue. Upstream writers enqueue operation entries {alu_control, x, z} and track `number_queued` against `MAX_Q_DEPTH`. This block owns the queue storage and drains it in order. For each entry it executes the selected ALU operation and presents the result on a valid/ready output. It flags invalid operations and dropped pushes, so the upstream "Queue full" condition becomes a hardware-visible status.

## Interface
Parameters:
- `DATA_W`, 8: operand width for x and z.
- `CTRL_W`, 2: alu_control width.
- `MAX_Q_DEPTH`, 8: queue depth in entries. Must be a power of 2, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `push` in 1: writer enqueue request.
- `push_ctrl` in CTRL_W: operation code.
- `push_x` in DATA_W: operand x.
- `push_z` in DATA_W: operand z.
- `full` out 1: `number_queued == MAX_Q_DEPTH`.
- `number_queued` out $clog2(MAX_Q_DEPTH)+1: current occupancy.
- `overflow` out 1: one-cycle pulse when `push` is dropped because the queue is full.
- `y_valid` out 1: result available.
- `y_ready` in 1: consumer accepts the result.
- `y` out 2*DATA_W: result.
- `y_err` out 1: qualifies `y`; set when the operation was invalid.

## Operation
- Push is accepted when `push && !full`, using registered `full`. A push while full is dropped and `overflow` pulses on the next cycle, even if a pop occurs in the same cycle.
- Pop is internal: the FSM reads the head entry into operand registers.
- Occupancy update per cycle:
  - accepted push and pop together: `number_queued` unchanged.
  - accepted push only: +1.
  - pop only: −1.
- Read and write pointers wrap modulo `MAX_Q_DEPTH`.
- FSM states:
  - IDLE: if `number_queued != 0`, pop the head into operand regs and go to EXEC.
  - EXEC: compute the result into `y`/`y_err`, set `y_valid`, go to HOLD.
  - HOLD: hold `y`, `y_err` and `y_valid` stable until `y_valid && y_ready`. On that handshake, pop the next entry and go to EXEC if the queue is non-empty; otherwise clear `y_valid` and go to IDLE.
- Arithmetic: x and z are unsigned and zero-extended to 2*DATA_W.
  - ctrl 0: y = x + z.
  - ctrl 1: y = x − z, wrapping modulo 2^(2*DATA_W).
  - ctrl 2: y = x * z.
  - any other code: y = 0, y_err = 1.
  - valid operations: y_err = 0.
- Reset values: `y_valid`=0, `y`=0, `y_err`=0, `overflow`=0, `full`=0, `number_queued`=0. FSM = IDLE, both pointers = 0. Storage contents are not reset.
- Reset mid-operation clears immediately. Queued entries and any in-flight result are discarded.

## Timing
- A push accepted at edge k is visible in `number_queued` after edge k.
- With the FSM in IDLE, the entry is popped at edge k+1 and `y_valid` rises after edge k+2. Push-to-result latency is 2 cycles.
- Sustained throughput with `y_ready` held at 1 is one result per 2 cycles: handshake edge → EXEC → `y_valid` again.
- `full` and `number_queued` are registered. A pop does not free a slot for a push in the same cycle.
- `y_valid` never drops without a handshake, except on reset.

## Configuration
- `ALU_QUEUE_MUL_EN` defined: ctrl 2 performs the multiply.
- Not defined: no multiplier is instantiated and ctrl 2 behaves as invalid (y = 0, y_err = 1).
- All other behaviour is identical in both builds.

## Structure
- Package `alu_queue_pkg` holds:
  - op-code constants `ALU_ADD`=0, `ALU_SUB`=1, `ALU_MUL`=2.
  - the entry struct {ctrl, x, z}.
  - the FSM state enum (IDLE, EXEC, HOLD).
- One sub-module, `alu_queue_fifo`: storage array, read/write pointers, `number_queued`, `full` and `overflow`.
- `alu_queue_reader` holds the FSM and the ALU datapath.

## Test plan
- Reset, then push {0, 8'd5, 8'd3} with `y_ready`=1 → `y_valid` high 2 cycles after the push edge, y=8, y_err=0, `number_queued` returns to 0.
- Push {1, 8'd3, 8'd5} → y=16'hFFFE, y_err=0. Push {3, 1, 1} → y=0, y_err=1.
- Push {2, 8'd255, 8'd255} → y=16'hFE01 with `ALU_QUEUE_MUL_EN`; y=0, y_err=1 without it.
- Hold `y_ready`=0 and push 10 entries with MAX_Q_DEPTH=8:
  - the first entry is popped into the FSM; the queue then fills, `full`=1, and further pushes pulse `overflow`.
  - release `y_ready` → results arrive in push order, exactly 9 of them.
- Keep `y_ready`=0 for 5 cycles with a result pending → `y` and `y_err` stay stable and `y_valid` stays 1.
- Assert `rst_n`=0 mid-stream while in HOLD → all outputs take their reset values immediately. After release, no stale results appear and the next push behaves as the first one after reset.
